lsu_mem_port: RTL and testbench

- Load/store unit that acts as the initiator on the data-memory port of the 3-stage pipeline.
- Takes one load/store request at a time from the execute stage.
- Drives byte-address, write-strobe and replicated write data into the synchronous 1-cycle-latency data memory.
- Captures read data, then aligns and sign/zero-extends it. Returns a tagged response to writeback.

---
 rtl/lsu_mem_port.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_mem_port
// Purpose  : Load/store unit driving a synchronous 1-cycle-latency data
//            memory. Accepts one request at a time, aligns/extends load
//            data and returns a tagged response to writeback.
// Option   : LSU_MISALIGN_SPLIT_EN - split misaligned half/word accesses
//            into two aligned beats instead of reporting an error.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_port #(
   parameter int AW   = 32,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [AW-1:0]   req_addr,
   input  logic [31:0]     req_wdata,
   input  logic [TAGW-1:0] req_rd,
   output logic            resp_valid,
   output logic [31:0]     resp_data,
   output logic [TAGW-1:0] resp_rd,
   output logic            resp_err,
   output logic            mem_re,
   output logic [AW-1:0]   mem_raddr,
   input  logic [31:0]     mem_rdata,
   output logic            mem_we,
   output logic [AW-1:0]   mem_waddr,
   output logic [31:0]     mem_wdata,
   output logic [3:0]      mem_wstrb
);

`ifdef LSU_MISALIGN_SPLIT_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0, ISSUE = 3'd1, DATA = 3'd2, ISSUE2 = 3'd3, DATA2 = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, ISSUE = 3'd1, DATA = 3'd2
   } state_t;
`endif

   state_t r_state, w_state_nxt;

   // Request fields latched at accept
   logic            r_we, r_uns, r_err;
   logic [1:0]      r_size, r_off;
   logic [TAGW-1:0] r_rd;

   // Next values of the registered outputs
   logic            w_resp_valid_nxt, w_resp_err_nxt, w_mem_re_nxt, w_mem_we_nxt;
   logic [31:0]     w_resp_data_nxt, w_mem_wdata_nxt;
   logic [TAGW-1:0] w_resp_rd_nxt;
   logic [AW-1:0]   w_mem_raddr_nxt, w_mem_waddr_nxt;
   logic [3:0]      w_mem_wstrb_nxt;

   // Request decode
   logic            w_accept, w_misal, w_illegal, w_err;
   logic [AW-1:0]   w_addr0;
   logic [31:0]     w_lane_data, w_store_data, w_load_word, w_load_ext;
   logic [3:0]      w_lane_strb, w_store_strb;

   assign req_ready = (r_state == IDLE);
   assign w_accept  = req_valid && req_ready;
   assign w_addr0   = {req_addr[AW-1:2], 2'b00};
   assign w_illegal = (req_size == 2'b11);
   assign w_misal   = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

   // Aligned store lanes: data is replicated so every lane carries it
   assign w_lane_data = (req_size == 2'b00) ? {4{req_wdata[7:0]}} :
                        (req_size == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;
   assign w_lane_strb = (req_size == 2'b00) ? (4'b0001 << req_addr[1:0]) :
                        (req_size == 2'b01) ? (req_addr[1] ? 4'b1100 : 4'b0011) :
                                              4'b1111;

`ifdef LSU_MISALIGN_SPLIT_EN
   logic            r_split;
   logic [AW-1:0]   r_addr1;
   logic [3:0]      r_strb1;
   logic [31:0]     r_buf;
   logic            w_split;
   logic [63:0]     w_wdbl, w_load_cat;
   logic [31:0]     w_rot;
   logic [3:0]      w_nmask;
   logic [7:0]      w_mask8;

   assign w_err      = w_illegal;
   assign w_split    = w_misal && !w_illegal;
   // Rotate left by the byte offset; each beat then strobes its own lanes
   assign w_wdbl     = {req_wdata, req_wdata};
   assign w_rot      = w_wdbl[6'd32 - {1'b0, req_addr[1:0], 3'b000} +: 32];
   assign w_nmask    = (req_size == 2'b01) ? 4'b0011 : 4'b1111;
   assign w_mask8    = {4'b0000, w_nmask} << req_addr[1:0];
   assign w_store_data = w_split ? w_rot : w_lane_data;
   assign w_store_strb = w_split ? w_mask8[3:0] : w_lane_strb;
   // Beat1 bytes sit above beat0 bytes; shifting by the offset merges them
   assign w_load_cat  = (r_state == DATA2) ? {mem_rdata, r_buf} : {32'b0, mem_rdata};
   assign w_load_word = w_load_cat[{r_off, 3'b000} +: 32];
`else
   assign w_err        = w_illegal || w_misal;
   assign w_store_data = w_lane_data;
   assign w_store_strb = w_lane_strb;
   assign w_load_word  = mem_rdata >> {r_off, 3'b000};
`endif

   function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] sz,
                                            input logic uns);
      case (sz)
         2'b00:   return uns ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
         2'b01:   return uns ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   assign w_load_ext = f_extend(w_load_word, r_size, r_uns);

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt      = r_state;
      w_resp_valid_nxt = 1'b0;
      w_resp_data_nxt  = 32'b0;
      w_resp_rd_nxt    = '0;
      w_resp_err_nxt   = 1'b0;
      w_mem_re_nxt     = 1'b0;
      w_mem_we_nxt     = 1'b0;
      w_mem_raddr_nxt  = mem_raddr;
      w_mem_waddr_nxt  = mem_waddr;
      w_mem_wdata_nxt  = mem_wdata;
      w_mem_wstrb_nxt  = mem_wstrb;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_state_nxt = ISSUE;
               if (!w_err) begin
                  if (req_we) begin
                     w_mem_we_nxt    = 1'b1;
                     w_mem_waddr_nxt = w_addr0;
                     w_mem_wdata_nxt = w_store_data;
                     w_mem_wstrb_nxt = w_store_strb;
                  end else begin
                     w_mem_re_nxt    = 1'b1;
                     w_mem_raddr_nxt = w_addr0;
                  end
               end
            end
         end
         ISSUE: begin
            if (r_err) begin
               w_resp_valid_nxt = 1'b1;
               w_resp_err_nxt   = 1'b1;
               w_resp_rd_nxt    = r_rd;
               w_state_nxt      = IDLE;
            end else if (r_we) begin
`ifdef LSU_MISALIGN_SPLIT_EN
               if (r_split) begin
                  w_mem_we_nxt    = 1'b1;
                  w_mem_waddr_nxt = r_addr1;
                  w_mem_wstrb_nxt = r_strb1;
                  w_state_nxt     = ISSUE2;
               end else
`endif
               begin
                  w_resp_valid_nxt = 1'b1;
                  w_state_nxt      = IDLE;
               end
            end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
               if (r_split) begin
                  w_mem_re_nxt    = 1'b1;
                  w_mem_raddr_nxt = r_addr1;
                  w_state_nxt     = ISSUE2;
               end else
`endif
               begin
                  w_state_nxt = DATA;
               end
            end
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         ISSUE2: begin
            if (r_we) begin
               w_resp_valid_nxt = 1'b1;
               w_state_nxt      = IDLE;
            end else begin
               w_state_nxt = DATA2;
            end
         end
         DATA2: begin
            w_resp_valid_nxt = 1'b1;
            w_resp_data_nxt  = w_load_ext;
            w_resp_rd_nxt    = r_rd;
            w_state_nxt      = IDLE;
         end
`endif
         DATA: begin
            w_resp_valid_nxt = 1'b1;
            w_resp_data_nxt  = w_load_ext;
            w_resp_rd_nxt    = r_rd;
            w_state_nxt      = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         resp_valid <= 1'b0;
         resp_data  <= 32'b0;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
         mem_re     <= 1'b0;
         mem_raddr  <= '0;
         mem_we     <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= 32'b0;
         mem_wstrb  <= 4'b0;
      end else begin
         r_state    <= w_state_nxt;
         resp_valid <= w_resp_valid_nxt;
         resp_data  <= w_resp_data_nxt;
         resp_rd    <= w_resp_rd_nxt;
         resp_err   <= w_resp_err_nxt;
         mem_re     <= w_mem_re_nxt;
         mem_raddr  <= w_mem_raddr_nxt;
         mem_we     <= w_mem_we_nxt;
         mem_waddr  <= w_mem_waddr_nxt;
         mem_wdata  <= w_mem_wdata_nxt;
         mem_wstrb  <= w_mem_wstrb_nxt;
      end
   end

   // Request field capture at accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we   <= 1'b0;
         r_uns  <= 1'b0;
         r_err  <= 1'b0;
         r_size <= 2'b0;
         r_off  <= 2'b0;
         r_rd   <= '0;
      end else if (w_accept) begin
         r_we   <= req_we;
         r_uns  <= req_unsigned;
         r_err  <= w_err;
         r_size <= req_size;
         r_off  <= req_addr[1:0];
         r_rd   <= req_rd;
      end
   end

`ifdef LSU_MISALIGN_SPLIT_EN
   // Split-beat context; beat0 read data arrives while beat1 is being issued
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_split <= 1'b0;
         r_addr1 <= '0;
         r_strb1 <= 4'b0;
         r_buf   <= 32'b0;
      end else begin
         if (w_accept) begin
            r_split <= w_split;
            r_addr1 <= w_addr0 + AW'(4);
            r_strb1 <= w_mask8[7:4];
         end
         if (r_state == ISSUE2 && !r_we) begin
            r_buf <= mem_rdata;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lsu_mem_port
// Purpose  : Scoreboard bench for lsu_mem_port. A byte-array reference model
//            predicts responses and memory beats; monitors compare on the
//            falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_port;
   localparam int AW   = 32;
   localparam int TAGW = 5;
`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0] req_size = 2'b0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [TAGW-1:0] req_rd = '0;
   logic req_ready, resp_valid, resp_err, mem_re, mem_we;
   logic [31:0] resp_data, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [TAGW-1:0] resp_rd;
   logic [AW-1:0] mem_raddr, mem_waddr;
   logic [3:0] mem_wstrb;

   lsu_mem_port #(.AW(AW), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_err(resp_err),
      .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb)
   );

   always #5 clk = ~clk;

   typedef struct { logic err; logic [31:0] data; logic [4:0] rd; int cyc; } resp_t;
   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } beat_t;

   resp_t resp_q[$];
   beat_t beat_q[$];
   resp_t er;
   beat_t eb;
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] dmem [0:63];     // memory seen by the DUT
   logic [7:0]  ref_mem [0:255]; // reference byte image

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous 1-cycle memory; garbage on rdata when not reading
   always @(posedge clk) begin
      if (mem_we)
         for (int i = 0; i < 4; i++)
            if (mem_wstrb[i]) dmem[mem_waddr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      if (mem_re) mem_rdata <= dmem[mem_raddr[7:2]];
      else        mem_rdata <= $urandom;
   end

   // Response and memory-beat monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (resp_valid) begin
            if (resp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_resp: got data 0x%08h required none", resp_data);
            end else begin
               er = resp_q.pop_front();
               chk("resp_err", 32'(resp_err), 32'(er.err));
               chk("resp_data", resp_data, er.data);
               chk("resp_rd", 32'(resp_rd), 32'(er.rd));
               chk("resp_cycle", 32'(cyc), 32'(er.cyc));
            end
         end
         if (mem_re || mem_we) begin
            if (beat_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_mem_access: got re=%0b we=%0b required none", mem_re, mem_we);
            end else begin
               eb = beat_q.pop_front();
               chk("mem_we", 32'(mem_we), 32'(eb.we));
               chk("mem_re", 32'(mem_re), 32'(!eb.we));
               chk("mem_addr", eb.we ? mem_waddr : mem_raddr, eb.addr);
               if (eb.we) begin
                  chk("mem_wdata", mem_wdata, eb.wdata);
                  chk("mem_wstrb", 32'(mem_wstrb), 32'(eb.strb));
               end
            end
         end
      end
   end

   // Reference model: predicts response and memory beats for one request
   task automatic predict(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int acc);
      int n, off;
      bit mis, err;
      logic [31:0] a0, v, d, rot;
      logic [3:0] s;
      logic [7:0] m, ix;
      n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off = int'(addr[1:0]);
      mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
      err = (size == 2'd3) || (mis && !SPLIT);
      a0  = {addr[31:2], 2'b00};
      if (err) begin
         resp_q.push_back('{1'b1, 32'b0, rd, acc + 1});
      end else if (we) begin
         for (int i = 0; i < n; i++) begin
            ix = addr[7:0] + 8'(i);
            ref_mem[ix] = wdata[8*i +: 8];
         end
         if (!mis) begin
            if (size == 2'd0)      begin s = 4'b0001 << off; d = {4{wdata[7:0]}}; end
            else if (size == 2'd1) begin s = addr[1] ? 4'b1100 : 4'b0011; d = {2{wdata[15:0]}}; end
            else                   begin s = 4'b1111; d = wdata; end
            beat_q.push_back('{1'b1, a0, d, s});
            resp_q.push_back('{1'b0, 32'b0, 5'd0, acc + 1});
         end else begin
            rot = (wdata << (8*off)) | (wdata >> (32 - 8*off));
            m = (n == 2) ? 8'h03 : 8'h0F;
            m = m << off;
            beat_q.push_back('{1'b1, a0, rot, m[3:0]});
            beat_q.push_back('{1'b1, a0 + 32'd4, rot, m[7:4]});
            resp_q.push_back('{1'b0, 32'b0, 5'd0, acc + 2});
         end
      end else begin
         v = 32'b0;
         for (int i = 0; i < n; i++) begin
            ix = addr[7:0] + 8'(i);
            v[8*i +: 8] = ref_mem[ix];
         end
         if (n == 1 && !uns && v[7])  v[31:8]  = '1;
         if (n == 2 && !uns && v[15]) v[31:16] = '1;
         beat_q.push_back('{1'b0, a0, 32'b0, 4'b0});
         if (mis) beat_q.push_back('{1'b0, a0 + 32'd4, 32'b0, 4'b0});
         resp_q.push_back('{1'b0, v, rd, acc + (mis ? 3 : 2)});
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      @(negedge clk);
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      chk("ready_before_req", 32'(req_ready), 32'd1);
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input bit hold);
      bit got = 0;
      int k = 0;
      wait_ready();
      req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
      predict(we, size, uns, addr, wdata, rd, cyc + 1);
      @(posedge clk);
      #1;
      if (hold) begin
         req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
         req_addr = 32'($urandom_range(0, 255)); req_wdata = $urandom; req_rd = 5'($urandom);
      end else begin
         req_valid = 1'b0;
      end
      while (!got && k < 8) begin
         @(negedge clk);
         if (resp_valid) got = 1;
         else chk("busy_ready", 32'(req_ready), 32'd0);
         k++;
      end
      req_valid = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got no response required one");
         resp_q.delete();
         beat_q.delete();
      end else begin
         chk("ready_after_resp", 32'(req_ready), 32'd1);
      end
   endtask

   // Reset asserted in the ISSUE cycle of an aligned word access
   task automatic do_reset_mid(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      wait_ready();
      req_we = we; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = addr; req_wdata = wdata; req_rd = 5'd21; req_valid = 1'b1;
      beat_q.push_back('{we, addr, we ? wdata : 32'b0, we ? 4'b1111 : 4'b0000});
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
      chk("rstmid_mem_re", 32'(mem_re), 32'd0);
      chk("rstmid_mem_we", 32'(mem_we), 32'd0);
      chk("rstmid_mem_waddr", mem_waddr, 32'd0);
      chk("rstmid_mem_raddr", mem_raddr, 32'd0);
      chk("rstmid_mem_wdata", mem_wdata, 32'd0);
      chk("rstmid_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rstmid_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_beats_left", 32'(beat_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      chk("rstmid_no_resp", 32'(resp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] sz;
      int r;
      for (int w = 0; w < 64; w++) begin
         dmem[w] = $urandom;
         for (int b = 0; b < 4; b++) ref_mem[w*4 + b] = dmem[w][8*b +: 8];
      end
      @(negedge clk);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_data", resp_data, 32'd0);
      chk("reset_mem_re", 32'(mem_re), 32'd0);
      chk("reset_mem_we", 32'(mem_we), 32'd0);
      chk("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd7, 1'b0);
      do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 5'd1, 1'b0);
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5'd9, 1'b0);
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5'd10, 1'b0);
      do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h8001, 5'd2, 1'b0);
      do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 5'd11, 1'b0);
      do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 5'd12, 1'b0);
      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 5'd4, 1'b0);
      do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h55667788, 5'd5, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h21, 32'h0, 5'd13, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd14, 1'b1);
      do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 5'd15, 1'b0);
      do_req(1'b1, 2'd3, 1'b0, 32'h44, 32'hCAFEF00D, 5'd16, 1'b0);

      do_reset_mid(1'b1, 32'h10, 32'h12345678);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd17, 1'b0);
      do_reset_mid(1'b0, 32'h20, 32'h0);
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd18, 1'b0);

      for (int t = 0; t < 300; t++) begin
         r  = int'($urandom_range(0, 9));
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         do_req(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 255)),
                $urandom, 5'($urandom), ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge clk);
      chk("resp_queue_empty", 32'(resp_q.size()), 32'd0);
      chk("beat_queue_empty", 32'(beat_q.size()), 32'd0);
      for (int w = 0; w < 64; w++)
         chk("final_memory", dmem[w], {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
